axi_wresp_monitor: RTL and testbench



---
 rtl/axi_wresp_pkg.sv | 39 +++
 rtl/axi_wresp_monitor_if.sv | 27 ++
 rtl/axi_wresp_sat_cnt.sv | 23 ++
 rtl/axi_wresp_monitor.sv | 191 +++++++++++++++++++
 tb/tb_axi_wresp_monitor.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_wresp_pkg.sv
// Shared definitions for the AXI-Lite write-response monitor: error indices,
// BRESP encodings and the B-channel state type.
package axi_wresp_pkg;

    localparam int unsigned ERR_N          = 8;
    localparam int unsigned ERR_UNEXP_B    = 0;
    localparam int unsigned ERR_AW_OVF     = 1;
    localparam int unsigned ERR_W_OVF      = 2;
    localparam int unsigned ERR_BVALID_DROP = 3;
    localparam int unsigned ERR_BRESP_CHG  = 4;
    localparam int unsigned ERR_BREADY_TO  = 5;
    localparam int unsigned ERR_BVALID_RST = 6;
    localparam int unsigned ERR_EXOKAY     = 7;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic {
        B_IDLE,
        B_STALL
    } b_state_t;

    function automatic logic [2:0] lowest_set(input logic [ERR_N-1:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ERR_N; i++) begin
            if (v[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_wresp_monitor_if.sv
// AXI-Lite AW/W/B handshake signals seen by the write-response monitor.
interface axi_wresp_monitor_if;

    logic       AXI_AWVALID;
    logic       AXI_AWREADY;
    logic       AXI_WVALID;
    logic       AXI_WREADY;
    logic [1:0] AXI_BRESP;
    logic       AXI_BVALID;
    logic       AXI_BREADY;

    modport master (
        output AXI_AWVALID, AXI_WVALID, AXI_BREADY,
        input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID
    );

    modport slave (
        input  AXI_AWVALID, AXI_WVALID, AXI_BREADY,
        output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID
    );

    modport monitor (
        input AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY,
              AXI_BRESP, AXI_BVALID, AXI_BREADY
    );

endinterface

// File: rtl/axi_wresp_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module axi_wresp_sat_cnt #(
    parameter int unsigned   W   = 16,
    parameter logic [W-1:0]  MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/axi_wresp_monitor.sv
// Passive AXI-Lite write-response protocol monitor with sticky error flags and
// saturating BRESP statistics. Optional AXI_WRESP_FIRST_ERR_EN adds first-error capture.
module axi_wresp_monitor
    import axi_wresp_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned MAXWAIT         = 5,
    parameter int unsigned CNT_W           = 16,
    localparam int unsigned PW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET,
    axi_wresp_monitor_if.monitor        axi,
    input  logic                        err_clr,
    output logic [ERR_N-1:0]            err_flags,
    output logic                        err_irq,
    output logic [PW-1:0]               aw_pend,
    output logic [PW-1:0]               w_pend,
    output logic [CNT_W-1:0]            okay_cnt,
    output logic [CNT_W-1:0]            slverr_cnt,
    output logic [CNT_W-1:0]            decerr_cnt
`ifdef AXI_WRESP_FIRST_ERR_EN
    ,
    output logic [2:0]                  first_err_idx,
    output logic [CNT_W-1:0]            first_err_time
`endif
);

    localparam int unsigned   WW       = $clog2(MAXWAIT + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_OUTSTANDING);

    logic             aw_hs, w_hs, b_hs;
    logic             aw_dec, w_dec, aw_ovf, w_ovf;
    logic [PW-1:0]    aw_pend_nxt, w_pend_nxt;
    b_state_t         state, state_nxt;
    logic [1:0]       bresp_lat;
    logic             stall_enter, stall_inc, bvalid_drop, bresp_chg;
    logic [WW-1:0]    wait_cnt;
    logic             rst_seen;
    logic [ERR_N-1:0] err_set;

    assign aw_hs = axi.AXI_AWVALID && axi.AXI_AWREADY;
    assign w_hs  = axi.AXI_WVALID  && axi.AXI_WREADY;
    assign b_hs  = axi.AXI_BVALID  && axi.AXI_BREADY;

    // Outstanding beat tracking; an overflowing beat is dropped and flagged.
    always_comb begin
        aw_dec      = b_hs && (aw_pend != '0);
        w_dec       = b_hs && (w_pend  != '0);
        aw_ovf      = aw_hs && (aw_pend == PEND_MAX) && !aw_dec;
        w_ovf       = w_hs  && (w_pend  == PEND_MAX) && !w_dec;
        aw_pend_nxt = aw_pend;
        w_pend_nxt  = w_pend;
        if (aw_hs && !aw_dec && !aw_ovf) begin
            aw_pend_nxt = aw_pend + PW'(1);
        end else if (!aw_hs && aw_dec) begin
            aw_pend_nxt = aw_pend - PW'(1);
        end
        if (w_hs && !w_dec && !w_ovf) begin
            w_pend_nxt = w_pend + PW'(1);
        end else if (!w_hs && w_dec) begin
            w_pend_nxt = w_pend - PW'(1);
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            state <= B_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stall_enter = 1'b0;
        stall_inc   = 1'b0;
        bvalid_drop = 1'b0;
        bresp_chg   = 1'b0;
        case (state)
            B_IDLE: begin
                if (axi.AXI_BVALID && !axi.AXI_BREADY) begin
                    state_nxt   = B_STALL;
                    stall_enter = 1'b1;
                end
            end
            B_STALL: begin
                if (!axi.AXI_BVALID) begin
                    bvalid_drop = 1'b1;
                    state_nxt   = B_IDLE;
                end else begin
                    bresp_chg = (axi.AXI_BRESP != bresp_lat);
                    if (axi.AXI_BREADY) begin
                        state_nxt = B_IDLE;
                    end else begin
                        stall_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = B_IDLE;
        endcase
    end

    axi_wresp_sat_cnt #(.W(WW), .MAX(WW'(MAXWAIT))) u_wait_cnt (
        .clk (AXI_ACLK),
        .rst (AXI_ARESET),
        .clr (stall_enter),
        .inc (stall_inc),
        .q   (wait_cnt)
    );

    // Timeout fires only on the increment that reaches MAXWAIT, so once per stall.
    always_comb begin
        err_set                  = '0;
        err_set[ERR_UNEXP_B]     = b_hs && ((aw_pend == '0) || (w_pend == '0));
        err_set[ERR_AW_OVF]      = aw_ovf;
        err_set[ERR_W_OVF]       = w_ovf;
        err_set[ERR_BVALID_DROP] = bvalid_drop;
        err_set[ERR_BRESP_CHG]   = bresp_chg;
        err_set[ERR_BREADY_TO]   = stall_inc && (wait_cnt == WW'(MAXWAIT - 1));
        err_set[ERR_BVALID_RST]  = rst_seen && axi.AXI_BVALID;
        err_set[ERR_EXOKAY]      = b_hs && (axi.AXI_BRESP == RESP_EXOKAY);
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            bresp_lat <= '0;
            aw_pend   <= '0;
            w_pend    <= '0;
            err_flags <= '0;
            err_irq   <= 1'b0;
            rst_seen  <= 1'b1;
        end else begin
            if (stall_enter) begin
                bresp_lat <= axi.AXI_BRESP;
            end
            aw_pend   <= aw_pend_nxt;
            w_pend    <= w_pend_nxt;
            err_flags <= (err_clr ? '0 : err_flags) | err_set;
            err_irq   <= |err_flags;
            rst_seen  <= 1'b0;
        end
    end

    axi_wresp_sat_cnt #(.W(CNT_W)) u_okay_cnt (
        .clk (AXI_ACLK),
        .rst (AXI_ARESET),
        .clr (1'b0),
        .inc (b_hs && (axi.AXI_BRESP == RESP_OKAY)),
        .q   (okay_cnt)
    );

    axi_wresp_sat_cnt #(.W(CNT_W)) u_slverr_cnt (
        .clk (AXI_ACLK),
        .rst (AXI_ARESET),
        .clr (1'b0),
        .inc (b_hs && (axi.AXI_BRESP == RESP_SLVERR)),
        .q   (slverr_cnt)
    );

    axi_wresp_sat_cnt #(.W(CNT_W)) u_decerr_cnt (
        .clk (AXI_ACLK),
        .rst (AXI_ARESET),
        .clr (1'b0),
        .inc (b_hs && (axi.AXI_BRESP == RESP_DECERR)),
        .q   (decerr_cnt)
    );

`ifdef AXI_WRESP_FIRST_ERR_EN
    logic [CNT_W-1:0] cyc_cnt;

    // A clear in the same cycle as a new error counts as rising from all-zero.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            cyc_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_time <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if ((err_set != '0) && ((err_flags == '0) || err_clr)) begin
                first_err_idx  <= lowest_set(err_set);
                first_err_time <= cyc_cnt;
            end else if (err_clr) begin
                first_err_idx  <= '0;
                first_err_time <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_wresp_monitor.sv
// Directed plus randomized bench for axi_wresp_monitor against a behavioural
// model of the write-response rules.
module tb_axi_wresp_monitor;
    import axi_wresp_pkg::*;

    localparam int unsigned MAXO = 4;
    localparam int unsigned MAXW = 5;
    localparam int unsigned CW   = 5;
    localparam int unsigned PWB  = 3;
    localparam int          SAT  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            err_clr;
    logic [7:0]      err_flags;
    logic            err_irq;
    logic [PWB-1:0]  aw_pend, w_pend;
    logic [CW-1:0]   okay_cnt, slverr_cnt, decerr_cnt;
`ifdef AXI_WRESP_FIRST_ERR_EN
    logic [2:0]      first_err_idx;
    logic [CW-1:0]   first_err_time;
`endif

    axi_wresp_monitor_if bus ();

    axi_wresp_monitor #(
        .MAX_OUTSTANDING (MAXO),
        .MAXWAIT         (MAXW),
        .CNT_W           (CW)
    ) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESET (rst),
        .axi        (bus),
        .err_clr    (err_clr),
        .err_flags  (err_flags),
        .err_irq    (err_irq),
        .aw_pend    (aw_pend),
        .w_pend     (w_pend),
        .okay_cnt   (okay_cnt),
        .slverr_cnt (slverr_cnt),
        .decerr_cnt (decerr_cnt)
`ifdef AXI_WRESP_FIRST_ERR_EN
        ,
        .first_err_idx  (first_err_idx),
        .first_err_time (first_err_time)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int n_checks   = 0;

    // Behavioural model state
    int         m_aw, m_w, m_ok, m_se, m_de;
    logic [7:0] m_flags;
    logic       m_irq;
    bit         m_stall, m_fresh;
    logic [1:0] m_lat;
    int         m_age;
    int         m_cyc, m_fidx, m_ftime;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("err_flags", 32'(err_flags), 32'(m_flags));
        chk("err_irq", 32'(err_irq), 32'(m_irq));
        chk("aw_pend", 32'(aw_pend), m_aw);
        chk("w_pend", 32'(w_pend), m_w);
        chk("okay_cnt", 32'(okay_cnt), m_ok);
        chk("slverr_cnt", 32'(slverr_cnt), m_se);
        chk("decerr_cnt", 32'(decerr_cnt), m_de);
`ifdef AXI_WRESP_FIRST_ERR_EN
        chk("first_err_idx", 32'(first_err_idx), m_fidx);
        chk("first_err_time", 32'(first_err_time), m_ftime);
`endif
    endtask

    task automatic model_reset();
        m_aw = 0; m_w = 0; m_ok = 0; m_se = 0; m_de = 0;
        m_flags = '0; m_irq = 1'b0;
        m_stall = 1'b0; m_fresh = 1'b1; m_lat = '0; m_age = 0;
        m_cyc = 0; m_fidx = 0; m_ftime = 0;
    endtask

    // Applies the rules for one clock edge given the inputs present at it.
    task automatic model_edge(input bit awv, awr, wv, wr, bv, br,
                              input logic [1:0] bresp, input bit clr);
        bit         awh, wh, bh;
        logic [7:0] set, base;
        int         na, nw;
        awh = awv && awr;
        wh  = wv && wr;
        bh  = bv && br;
        set = '0;
        if (m_fresh && bv) set[6] = 1'b1;
        m_fresh = 1'b0;
        if (bh && (m_aw == 0 || m_w == 0)) set[0] = 1'b1;
        if (bh && bresp == 2'd1) set[7] = 1'b1;
        na = m_aw + int'(awh) - ((bh && m_aw > 0) ? 1 : 0);
        nw = m_w  + int'(wh)  - ((bh && m_w  > 0) ? 1 : 0);
        if (na > MAXO) begin set[1] = 1'b1; na = MAXO; end
        if (nw > MAXO) begin set[2] = 1'b1; nw = MAXO; end
        m_aw = na;
        m_w  = nw;
        if (!m_stall) begin
            if (bv && !br) begin
                m_stall = 1'b1;
                m_lat   = bresp;
                m_age   = 0;
            end
        end else begin
            if (bv && bresp != m_lat) set[4] = 1'b1;
            if (!bv) begin
                set[3]  = 1'b1;
                m_stall = 1'b0;
            end else if (br) begin
                m_stall = 1'b0;
            end else if (m_age < MAXW) begin
                m_age++;
                if (m_age == MAXW) set[5] = 1'b1;
            end
        end
        if (bh) begin
            case (bresp)
                2'd0: if (m_ok < SAT) m_ok++;
                2'd2: if (m_se < SAT) m_se++;
                2'd3: if (m_de < SAT) m_de++;
                default: ;
            endcase
        end
        base  = clr ? 8'h00 : m_flags;
        m_irq = |m_flags;
        if (base == 8'h00 && set != 8'h00) begin
            for (int i = 0; i < 8; i++) begin
                if (set[i]) begin
                    m_fidx = i;
                    break;
                end
            end
            m_ftime = m_cyc;
        end else if (clr) begin
            m_fidx  = 0;
            m_ftime = 0;
        end
        m_cyc   = (m_cyc + 1) % (1 << CW);
        m_flags = base | set;
    endtask

    task automatic apply(input bit awv, awr, wv, wr, bv, br,
                         input logic [1:0] bresp, input bit clr);
        bus.AXI_AWVALID = awv;
        bus.AXI_AWREADY = awr;
        bus.AXI_WVALID  = wv;
        bus.AXI_WREADY  = wr;
        bus.AXI_BVALID  = bv;
        bus.AXI_BREADY  = br;
        bus.AXI_BRESP   = bresp;
        err_clr         = clr;
        @(posedge clk);
        model_edge(awv, awr, wv, wr, bv, br, bresp, clr);
        #1;
        check_all();
        vectors++;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic do_reset(input bit bv_hold);
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_AWREADY = 1'b0;
        bus.AXI_WVALID  = 1'b0;
        bus.AXI_WREADY  = 1'b0;
        bus.AXI_BVALID  = bv_hold;
        bus.AXI_BREADY  = 1'b0;
        bus.AXI_BRESP   = 2'd0;
        err_clr         = 1'b0;
        rst             = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        vectors++;
        rst = 1'b0;
    endtask

    initial begin
        bit         r_awv, r_awr, r_wv, r_wr, r_bv, r_br, r_clr;
        logic [1:0] r_bresp;
        int         br_pct;

        rst = 1'b1;
        do_reset(0);

        // Basic AW, W, B OKAY sequence
        apply(1, 1, 0, 0, 0, 0, 2'd0, 0);
        chk("t1_aw_pend", 32'(aw_pend), 1);
        apply(0, 0, 1, 1, 0, 0, 2'd0, 0);
        chk("t1_w_pend", 32'(w_pend), 1);
        apply(0, 0, 0, 0, 1, 1, 2'd0, 0);
        chk("t1_pend_zero", 32'({aw_pend, w_pend}), 0);
        chk("t1_okay", 32'(okay_cnt), 1);
        chk("t1_flags", 32'(err_flags), 0);

        // B handshake with nothing pending, AW and W in the same cycle
        apply(1, 1, 1, 1, 1, 1, 2'd0, 0);
        chk("t2_flags", 32'(err_flags), 32'h01);
        chk("t2_irq_lag", 32'(err_irq), 0);
        idle();
        chk("t2_irq", 32'(err_irq), 1);
        chk("t2_pend", 32'({aw_pend, w_pend}), 32'h09);
        apply(0, 0, 0, 0, 0, 0, 2'd0, 1);
        apply(0, 0, 0, 0, 1, 1, 2'd0, 0);

        // Long stall: timeout, then BRESP change, then BVALID drop
        for (int k = 1; k <= 7; k++) begin
            apply(0, 0, 0, 0, 1, 0, 2'd2, 0);
            chk("t3_to_timing", 32'(err_flags), (k >= 6) ? 32'h20 : 32'h00);
        end
        apply(0, 0, 0, 0, 1, 0, 2'd3, 0);
        chk("t3_bresp_chg", 32'(err_flags), 32'h30);
        idle();
        chk("t3_drop", 32'(err_flags), 32'h38);
        apply(0, 0, 0, 0, 0, 0, 2'd0, 1);

        // AW overflow then clear
        for (int k = 1; k <= 5; k++) apply(1, 1, 0, 0, 0, 0, 2'd0, 0);
        chk("t4_aw_pend", 32'(aw_pend), 4);
        chk("t4_ovf", 32'(err_flags), 32'h02);
        apply(0, 0, 0, 0, 0, 0, 2'd0, 1);
        chk("t4_clr", 32'(err_flags), 0);
        chk("t4_pend_hold", 32'(aw_pend), 4);

        // Reset in the middle of a stall raises nothing afterwards
        apply(0, 0, 0, 0, 1, 0, 2'd0, 0);
        do_reset(0);
        idle();
        chk("t_mid_rst", 32'(err_flags), 0);

        // Reset released with BVALID high
        do_reset(1);
        apply(0, 0, 0, 0, 1, 0, 2'd0, 0);
        chk("t5_bvalid_rst", 32'(err_flags), 32'h40);
        apply(1, 1, 1, 1, 1, 0, 2'd0, 0);
        apply(0, 0, 0, 0, 1, 1, 2'd0, 1);
        chk("t5_clean", 32'(err_flags), 0);
        apply(1, 1, 1, 1, 0, 0, 2'd0, 0);
        apply(0, 0, 0, 0, 1, 1, 2'd1, 0);
        chk("t5_exokay", 32'(err_flags), 32'h80);
        chk("t5_exokay_cnt", 32'({okay_cnt, slverr_cnt, decerr_cnt}), 32'(1 << (2 * CW)));
        apply(0, 0, 0, 0, 0, 0, 2'd0, 1);
        apply(1, 1, 1, 1, 0, 0, 2'd0, 0);
        for (int k = 0; k < 3; k++) apply(1, 1, 1, 1, 1, 1, 2'd2, 0);
        for (int k = 0; k < 2; k++) apply(1, 1, 1, 1, 1, 1, 2'd3, 0);
        chk("t5_slverr", 32'(slverr_cnt), 3);
        chk("t5_decerr", 32'(decerr_cnt), 2);
        chk("t5_flags", 32'(err_flags), 0);

        // Statistics saturation
        for (int k = 0; k < 35; k++) apply(1, 1, 1, 1, 1, 1, 2'd0, 0);
        chk("sat_okay", 32'(okay_cnt), 32'(SAT));

        // First-error capture: UNEXP_B at cycle 20, timeout later
        do_reset(0);
        for (int k = 0; k < 20; k++) idle();
        apply(0, 0, 0, 0, 1, 1, 2'd0, 0);
        for (int k = 0; k < 7; k++) apply(0, 0, 0, 0, 1, 0, 2'd0, 0);
        chk("fe_flags", 32'(err_flags), 32'h21);
`ifdef AXI_WRESP_FIRST_ERR_EN
        chk("fe_idx", 32'(first_err_idx), 0);
        chk("fe_time", 32'(first_err_time), 20);
`endif
        idle();

        // Randomized traffic
        r_bv    = 1'b0;
        r_bresp = 2'd0;
        br_pct  = 40;
        for (int n = 0; n < 1200; n++) begin
            if (n % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       br_pct = 10;
                    1:       br_pct = 40;
                    default: br_pct = 80;
                endcase
            end
            if ($urandom_range(0, 149) == 0) do_reset(1'($urandom_range(0, 1)));
            r_awv = $urandom_range(0, 9) < 6;
            r_awr = $urandom_range(0, 9) < 6;
            r_wv  = $urandom_range(0, 9) < 6;
            r_wr  = $urandom_range(0, 9) < 6;
            if ($urandom_range(0, 3) == 0) r_bv = ~r_bv;
            if ($urandom_range(0, 5) == 0) r_bresp = 2'($urandom_range(0, 3));
            r_br  = $urandom_range(0, 99) < br_pct;
            r_clr = $urandom_range(0, 11) == 0;
            apply(r_awv, r_awr, r_wv, r_wr, r_bv, r_br, r_bresp, r_clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
